// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: states, opcodes,
// instruction classes and the writeback / PC source selects.
package rv32i_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // CLS_NONE doubles as "illegal opcode" out of the decoder.
    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_OP     = 4'd1,
        CLS_OPIMM  = 4'd2,
        CLS_LUI    = 4'd3,
        CLS_AUIPC  = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_BRANCH = 4'd7,
        CLS_LOAD   = 4'd8,
        CLS_STORE  = 4'd9,
        CLS_FENCE  = 4'd10,
        CLS_SYSTEM = 4'd11
    } cls_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    function automatic cls_t decode_class(input logic [6:0] opc);
        cls_t c;
        case (opc)
            OPC_OP:     c = CLS_OP;
            OPC_OPIMM:  c = CLS_OPIMM;
            OPC_LUI:    c = CLS_LUI;
            OPC_AUIPC:  c = CLS_AUIPC;
            OPC_JAL:    c = CLS_JAL;
            OPC_JALR:   c = CLS_JALR;
            OPC_BRANCH: c = CLS_BRANCH;
            OPC_LOAD:   c = CLS_LOAD;
            OPC_STORE:  c = CLS_STORE;
            OPC_FENCE:  c = CLS_FENCE;
            OPC_SYSTEM: c = CLS_SYSTEM;
            default:    c = CLS_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv32i_bus_timer.sv
// Wait-cycle counter for one bus request. Counts cycles spent waiting for an
// ack and flags expiry on the last allowed waiting cycle. BUS_TIMEOUT=0
// disables expiry entirely.
module rv32i_bus_timer #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int TW = ($clog2(BUS_TIMEOUT + 1) > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam bit ENABLED = (BUS_TIMEOUT > 0);
    localparam logic [TW-1:0] LIMIT = ENABLED ? TW'(BUS_TIMEOUT - 1) : '0;

    logic [TW-1:0] count_q;

    // Count waiting cycles; saturate at the limit so the value never wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (inc_i && ENABLED && (count_q != LIMIT)) begin
            count_q <= count_q + TW'(1);
        end
    end

    // Expiry only in a waiting cycle, so an ack in the same cycle wins.
    assign expire_o = ENABLED && inc_i && (count_q == LIMIT);

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle sequencer for the RV32I datapath: FETCH/DECODE/EXEC/MEM/WB
// with a sticky FAULT state for illegal opcodes and bus timeouts.
// Bus handshake: mem_req_o is held high from the first request cycle until
// the cycle in which mem_ack_i is seen high; that cycle completes the
// transfer and the request is never withdrawn before it.
module rv32i_ctrl_fsm
    import rv32i_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       br_taken_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_addr_sel_o,
    output logic       ir_we_o,
    output logic       mdr_we_o,
    output logic       ari_o,
    output logic       ar_o,
    output logic       br_o,
    output logic       lui_auipc_o,
    output logic       alu_force_add_o,
    output logic       alu_a_sel_o,
    output logic       rf_we_o,
    output logic [1:0] wb_sel_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    state_t state_q, state_d;
    cls_t   cls_q;
    cls_t   dec_cls;
    logic   waiting, timer_inc, timer_expire;
    logic   wr_ok;

    assign dec_cls   = decode_class(opcode_i);
    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timer_inc = waiting && !mem_ack_i;
    // A reset cycle must not commit any architectural write.
    assign wr_ok     = !rst_i;

    // Leaving a request state (or never being in one) clears the timer, so it
    // always starts from zero on entry to FETCH or MEM.
    rv32i_bus_timer #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!timer_inc),
        .inc_i    (timer_inc),
        .expire_o (timer_expire)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Instruction class is captured once, at the end of DECODE.
    always_ff @(posedge clk_i) begin
        if (rst_i)                    cls_q <= CLS_NONE;
        else if (state_q == S_DECODE) cls_q <= dec_cls;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack_i)         state_d = S_DECODE;
                else if (timer_expire) state_d = S_FAULT;
            end
            S_DECODE: state_d = (dec_cls == CLS_NONE) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC,
                    CLS_JAL, CLS_JALR:                 state_d = S_WB;
                    CLS_LOAD, CLS_STORE:               state_d = S_MEM;
                    CLS_BRANCH, CLS_FENCE, CLS_SYSTEM: state_d = S_FETCH;
                    default:                           state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (mem_ack_i)         state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
                else if (timer_expire) state_d = S_FAULT;
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Output decode: Moore on state/class, plus the ack- and branch-qualified terms.
    always_comb begin
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_sel_o  = 1'b0;
        ir_we_o         = 1'b0;
        mdr_we_o        = 1'b0;
        ari_o           = 1'b0;
        ar_o            = 1'b0;
        br_o            = 1'b0;
        lui_auipc_o     = 1'b0;
        alu_force_add_o = 1'b0;
        alu_a_sel_o     = 1'b0;
        rf_we_o         = 1'b0;
        wb_sel_o        = WB_ALU;
        pc_we_o         = 1'b0;
        pc_sel_o        = PC_PLUS4;
        fault_o         = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o = 1'b1;
                ir_we_o   = mem_ack_i && wr_ok;
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_OP:    ar_o  = 1'b1;
                    CLS_OPIMM: ari_o = 1'b1;
                    CLS_LUI:   lui_auipc_o = 1'b1;
                    CLS_AUIPC: begin
                        lui_auipc_o = 1'b1;
                        alu_a_sel_o = 1'b1;
                    end
                    CLS_BRANCH: begin
                        br_o     = 1'b1;
                        pc_we_o  = wr_ok;
                        pc_sel_o = br_taken_i ? PC_BRANCH : PC_PLUS4;
                    end
                    CLS_LOAD, CLS_STORE, CLS_JALR: alu_force_add_o = 1'b1;
                    CLS_JAL: begin
                        alu_force_add_o = 1'b1;
                        alu_a_sel_o     = 1'b1;
                    end
                    CLS_FENCE, CLS_SYSTEM: pc_we_o = wr_ok;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req_o       = 1'b1;
                mem_addr_sel_o  = 1'b1;
                mem_we_o        = (cls_q == CLS_STORE);
                alu_force_add_o = 1'b1;
                mdr_we_o        = mem_ack_i && (cls_q == CLS_LOAD) && wr_ok;
                pc_we_o         = mem_ack_i && (cls_q == CLS_STORE) && wr_ok;
            end
            S_WB: begin
                rf_we_o = wr_ok;
                pc_we_o = wr_ok;
                case (cls_q)
                    CLS_LOAD:          wb_sel_o = WB_MDR;
                    CLS_JAL, CLS_JALR: wb_sel_o = WB_PC4;
                    CLS_LUI:           wb_sel_o = WB_IMM;
                    default:           wb_sel_o = WB_ALU;
                endcase
                if (cls_q == CLS_JAL || cls_q == CLS_JALR) pc_sel_o = PC_JUMP;
            end
            S_FAULT: fault_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Directed bench for rv32i_ctrl_fsm with BUS_TIMEOUT=4. The driver pushes the
// hand-derived expected output word for every cycle it drives; the monitor
// pops one word per cycle on the falling edge and compares.
module tb_rv32i_ctrl_fsm;

  localparam int W = 21;

  // Expected-word fields: {state[20:18], mem_req, mem_we, mem_addr_sel, ir_we,
  // mdr_we, ari, ar, br, lui_auipc, force_add, a_sel, rf_we, wb_sel[5:4],
  // pc_we, pc_sel[2:1], fault}
  localparam logic [W-1:0] ST_F    = 21'd0 << 18;
  localparam logic [W-1:0] ST_D    = 21'd1 << 18;
  localparam logic [W-1:0] ST_E    = 21'd2 << 18;
  localparam logic [W-1:0] ST_M    = 21'd3 << 18;
  localparam logic [W-1:0] ST_W    = 21'd4 << 18;
  localparam logic [W-1:0] ST_X    = 21'd5 << 18;
  localparam logic [W-1:0] M_REQ   = 21'd1 << 17;
  localparam logic [W-1:0] M_MWE   = 21'd1 << 16;
  localparam logic [W-1:0] M_ASM   = 21'd1 << 15;
  localparam logic [W-1:0] M_IRWE  = 21'd1 << 14;
  localparam logic [W-1:0] M_MDRWE = 21'd1 << 13;
  localparam logic [W-1:0] M_ARI   = 21'd1 << 12;
  localparam logic [W-1:0] M_AR    = 21'd1 << 11;
  localparam logic [W-1:0] M_BR    = 21'd1 << 10;
  localparam logic [W-1:0] M_LUI   = 21'd1 << 9;
  localparam logic [W-1:0] M_FADD  = 21'd1 << 8;
  localparam logic [W-1:0] M_ASEL  = 21'd1 << 7;
  localparam logic [W-1:0] M_RFWE  = 21'd1 << 6;
  localparam logic [W-1:0] M_WB1   = 21'd1 << 4;
  localparam logic [W-1:0] M_WB2   = 21'd2 << 4;
  localparam logic [W-1:0] M_WB3   = 21'd3 << 4;
  localparam logic [W-1:0] M_PCWE  = 21'd1 << 3;
  localparam logic [W-1:0] M_PS1   = 21'd1 << 1;
  localparam logic [W-1:0] M_PS2   = 21'd2 << 1;
  localparam logic [W-1:0] M_FAULT = 21'd1;

  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_OPIMM  = 7'b0010011;
  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_FENCE  = 7'b0001111;
  localparam logic [6:0] O_SYSTEM = 7'b1110011;
  localparam logic [6:0] O_BAD    = 7'b1111111;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] op;
  logic       br;
  logic       ack;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, mdr_we;
  logic       ari, ar, br_s, lui_auipc, force_add, a_sel, rf_we;
  logic [1:0] wb_sel, pc_sel;
  logic       pc_we, fault;
  logic [2:0] state;

  rv32i_ctrl_fsm #(.BUS_TIMEOUT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .opcode_i        (op),
    .br_taken_i      (br),
    .mem_ack_i       (ack),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_addr_sel_o  (mem_addr_sel),
    .ir_we_o         (ir_we),
    .mdr_we_o        (mdr_we),
    .ari_o           (ari),
    .ar_o            (ar),
    .br_o            (br_s),
    .lui_auipc_o     (lui_auipc),
    .alu_force_add_o (force_add),
    .alu_a_sel_o     (a_sel),
    .rf_we_o         (rf_we),
    .wb_sel_o        (wb_sel),
    .pc_we_o         (pc_we),
    .pc_sel_o        (pc_sel),
    .fault_o         (fault),
    .state_o         (state)
  );

  logic [W-1:0] obs;
  assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, ari, ar, br_s,
                lui_auipc, force_add, a_sel, rf_we, wb_sel, pc_we, pc_sel, fault};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, obs, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input string nm, input logic a, input logic b, input logic r,
                     input logic [W-1:0] e);
    ack = a;
    br  = b;
    rst = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string nm, input logic [6:0] opc);
    op = opc;
    cyc({nm, "_fetch"}, 1'b1, rb(), 1'b0, ST_F | M_REQ | M_IRWE);
    cyc({nm, "_decode"}, rb(), rb(), 1'b0, ST_D);
  endtask

  task automatic run_simple(input string nm, input logic [6:0] opc,
                            input logic [W-1:0] ex, input logic [W-1:0] wb);
    fetch_decode(nm, opc);
    cyc({nm, "_exec"}, rb(), rb(), 1'b0, ST_E | ex);
    cyc({nm, "_wb"}, rb(), rb(), 1'b0, ST_W | wb);
  endtask

  task automatic run_branch(input string nm, input logic taken);
    fetch_decode(nm, O_BRANCH);
    cyc({nm, "_exec"}, rb(), taken, 1'b0,
        ST_E | M_BR | M_PCWE | (taken ? M_PS1 : 21'd0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    op  = O_OP;
    br  = 1'b0;
    ack = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 1'b0, 1'b0, 1'b1, ST_F | M_REQ);

    run_simple("op",    O_OP,    M_AR,            M_RFWE | M_PCWE);
    run_simple("opimm", O_OPIMM, M_ARI,           M_RFWE | M_PCWE);
    run_simple("lui",   O_LUI,   M_LUI,           M_RFWE | M_PCWE | M_WB3);
    run_simple("auipc", O_AUIPC, M_LUI | M_ASEL,  M_RFWE | M_PCWE);
    run_simple("jal",   O_JAL,   M_FADD | M_ASEL, M_RFWE | M_PCWE | M_WB2 | M_PS2);
    run_simple("jalr",  O_JALR,  M_FADD,          M_RFWE | M_PCWE | M_WB2 | M_PS2);

    // LOAD with three waiting MEM cycles: 8 cycles total, one MDR pulse.
    fetch_decode("load", O_LOAD);
    cyc("load_exec", rb(), rb(), 1'b0, ST_E | M_FADD);
    for (int i = 0; i < 3; i++) cyc("load_mem_wait", 1'b0, rb(), 1'b0, ST_M | M_REQ | M_ASM | M_FADD);
    cyc("load_mem_ack", 1'b1, rb(), 1'b0, ST_M | M_REQ | M_ASM | M_FADD | M_MDRWE);
    cyc("load_wb", rb(), rb(), 1'b0, ST_W | M_RFWE | M_PCWE | M_WB1);

    fetch_decode("store", O_STORE);
    cyc("store_exec", rb(), rb(), 1'b0, ST_E | M_FADD);
    cyc("store_mem_ack", 1'b1, rb(), 1'b0, ST_M | M_REQ | M_ASM | M_MWE | M_FADD | M_PCWE);

    run_branch("br_taken", 1'b1);
    run_branch("br_not_taken", 1'b0);

    fetch_decode("fence", O_FENCE);
    cyc("fence_exec", rb(), rb(), 1'b0, ST_E | M_PCWE);
    fetch_decode("system", O_SYSTEM);
    cyc("system_exec", rb(), rb(), 1'b0, ST_E | M_PCWE);

    // Ack in the last allowed FETCH cycle wins over the timeout.
    op = O_OP;
    for (int i = 0; i < 3; i++) cyc("late_ack_wait", 1'b0, rb(), 1'b0, ST_F | M_REQ);
    cyc("late_ack_fetch", 1'b1, rb(), 1'b0, ST_F | M_REQ | M_IRWE);
    cyc("late_ack_decode", rb(), rb(), 1'b0, ST_D);
    cyc("late_ack_exec", rb(), rb(), 1'b0, ST_E | M_AR);
    cyc("late_ack_wb", rb(), rb(), 1'b0, ST_W | M_RFWE | M_PCWE);

    // Reset while a STORE waits in MEM: back to FETCH, nothing committed.
    fetch_decode("st_rst", O_STORE);
    cyc("st_rst_exec", rb(), rb(), 1'b0, ST_E | M_FADD);
    cyc("st_rst_mem", 1'b0, rb(), 1'b1, ST_M | M_REQ | M_ASM | M_MWE | M_FADD);
    cyc("st_rst_after", 1'b0, rb(), 1'b0, ST_F | M_REQ);

    // Illegal opcode: FAULT from DECODE, sticky until reset.
    fetch_decode("illegal", O_BAD);
    for (int i = 0; i < 3; i++) cyc("illegal_hold", rb(), rb(), 1'b0, ST_X | M_FAULT);
    cyc("illegal_rst", rb(), rb(), 1'b1, ST_X | M_FAULT);

    // FETCH timeout: fourth unacked request cycle expires.
    for (int i = 0; i < 4; i++) cyc("fetch_to_wait", 1'b0, rb(), 1'b0, ST_F | M_REQ);
    for (int i = 0; i < 4; i++) cyc("fetch_to_hold", rb(), rb(), 1'b0, ST_X | M_FAULT);
    cyc("fetch_to_rst", rb(), rb(), 1'b1, ST_X | M_FAULT);

    // MEM timeout on a LOAD.
    fetch_decode("mem_to", O_LOAD);
    cyc("mem_to_exec", rb(), rb(), 1'b0, ST_E | M_FADD);
    for (int i = 0; i < 4; i++) cyc("mem_to_wait", 1'b0, rb(), 1'b0, ST_M | M_REQ | M_ASM | M_FADD);
    cyc("mem_to_fault", rb(), rb(), 1'b0, ST_X | M_FAULT);
    cyc("mem_to_rst", rb(), rb(), 1'b1, ST_X | M_FAULT);

    // Recovery after reset.
    run_simple("recover", O_OP, M_AR, M_RFWE | M_PCWE);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_ctrl_fsm.md
# rv32i_ctrl_fsm

Multi-cycle sequencer for the RV32I MCU datapath. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. In each state it drives the instruction-class strobes into the ALU decoder, the register-file/PC/IR write enables and the memory request handshake. It sits between the instruction register, the ALU decode/ALU and the memory bus, and flags a sticky fault on an illegal opcode or a bus timeout.

## Interface
Parameters:
- BUS_TIMEOUT, 16: max wait cycles for mem_ack_i per request; 0 disables timeout.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- opcode_i  in  7  instr[6:0] from the instruction register.
- br_taken_i  in  1  branch condition from the ALU, valid in EXEC.
- mem_ack_i  in  1  bus acknowledge; ignored outside FETCH/MEM.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  write qualifier for mem_req_o (store).
- mem_addr_sel_o  out  1  0 = PC, 1 = ALU result.
- ir_we_o  out  1  load the instruction register.
- mdr_we_o  out  1  load the memory data register.
- ari_o, ar_o, br_o, lui_auipc_o  out  1 each  class strobes to the ALU decoder.
- alu_force_add_o  out  1  force ALU add (LOAD/STORE/JAL/JALR address).
- alu_a_sel_o  out  1  0 = rs1, 1 = PC.
- rf_we_o  out  1  register-file write.
- wb_sel_o  out  2  0 = ALU, 1 = MDR, 2 = PC+4, 3 = immediate.
- pc_we_o  out  1  PC write.
- pc_sel_o  out  2  0 = PC+4, 1 = branch target, 2 = jump target (ALU).
- fault_o  out  1  sticky fault.
- state_o  out  3  current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
- Reset: state FETCH, class register cleared, timer 0, fault_o=0. Every output is 0 except the FETCH defaults: mem_req_o=1, mem_addr_sel_o=0.
- **FETCH**
  - Drives mem_req_o=1, mem_we_o=0, mem_addr_sel_o=0.
  - On mem_ack_i: ir_we_o=1 in the same cycle, then go to DECODE.
- **DECODE**
  - Classifies opcode_i into the registered class:
    - OP 0110011, OP-IMM 0010011
    - LUI 0110111, AUIPC 0010111
    - JAL 1101111, JALR 1100111
    - BRANCH 1100011, LOAD 0000011, STORE 0100011
    - FENCE 0001111, SYSTEM 1110011
  - Any other opcode goes to FAULT; otherwise go to EXEC.
- **EXEC** asserts exactly one class strobe, or alu_force_add_o. Per class:
  - OP: ar_o → WB.
  - OP-IMM: ari_o → WB.
  - LUI/AUIPC: lui_auipc_o (AUIPC adds alu_a_sel_o=1) → WB.
  - BRANCH: br_o, pc_we_o=1, pc_sel_o = br_taken_i ? 1 : 0 → FETCH.
  - LOAD/STORE: alu_force_add_o → MEM.
  - JAL: alu_force_add_o, alu_a_sel_o=1 → WB.
  - JALR: alu_force_add_o → WB.
  - FENCE/SYSTEM: pc_we_o=1, pc_sel_o=0 → FETCH (treated as NOP).
- **MEM**
  - Drives mem_req_o=1, mem_addr_sel_o=1, mem_we_o=(STORE), alu_force_add_o held.
  - On ack, LOAD: mdr_we_o=1 → WB.
  - On ack, STORE: pc_we_o=1, pc_sel_o=0 → FETCH.
- **WB**
  - rf_we_o=1 and pc_we_o=1.
  - wb_sel_o: 1 for LOAD, 2 for JAL/JALR, 3 for LUI, 0 otherwise.
  - pc_sel_o: 2 for JAL/JALR, else 0.
  - Next state FETCH.
- **FAULT**
  - Absorbing; only rst_i exits.
  - fault_o=1; all other outputs 0.
- Bus timer:
  - Cleared on every entry to FETCH or MEM.
  - Increments each waiting cycle without an ack.
  - When it equals BUS_TIMEOUT-1 with no ack, go to FAULT.
  - An ack in that same cycle wins.

## Timing
- Outputs are Moore (state + class register), except these, which are combinational in the current cycle:
  - ir_we_o, mdr_we_o, and the exit-cycle pc_we_o from MEM (all on mem_ack_i).
  - pc_sel_o in EXEC for BRANCH (on br_taken_i).
- Minimum latency with ack in the first request cycle:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/FENCE/SYSTEM: 3 cycles.
- mem_req_o stays high until the ack cycle. The controller never drops a request early.
- rst_i asserted mid-instruction: next state FETCH, timer and fault cleared, no further write enables.
- Timer width is max(1, $clog2(BUS_TIMEOUT+1)).

## Structure
- Package rv32i_ctrl_pkg holds:
  - state encodings;
  - opcode constants;
  - class enumeration;
  - wb_sel and pc_sel encodings.
- Sub-module rv32i_bus_timer holds the clear/increment/expire counter, with BUS_TIMEOUT as its parameter.

## Test plan
- OP instruction (opcode 0110011), ack in the first FETCH cycle → state sequence 0,1,2,4,0; ar_o high only in EXEC; rf_we_o=1 and wb_sel_o=0 in WB.
- LOAD, ack delayed 3 cycles in MEM → mdr_we_o pulses once on the ack cycle; WB has wb_sel_o=1; total 8 cycles.
- BRANCH:
  - br_taken_i=1 → pc_sel_o=1, pc_we_o=1 in EXEC, rf_we_o never high.
  - br_taken_i=0 → pc_sel_o=0.
- BUS_TIMEOUT=4, no ack in FETCH → FAULT entered after 4 request cycles; fault_o stays 1 until rst_i.
- Ack arriving exactly in the 4th cycle → no fault, state goes to DECODE.
- Opcode 1111111 → FAULT from DECODE.
- rst_i asserted in MEM of a STORE → next cycle FETCH, mem_we_o=0, fault_o=0.
